// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// One-bit full adder used as the bit-slice cell of the 16-bit ripple-carry
// adder (add16 chains 16 of these, CYO of slice i feeding CYI of slice i+1).
//
// The SUM/CYO/P/G path is purely combinational and has no dependence on
// CLK or RST_N, so a ripple chain can leave the clock and reset unconnected.
// A registered copy of the same four terms is provided for pipelined or
// carry-lookahead reuse.
//
// Parameters
//   REG_EN  1: SUM_Q/CYO_Q/P_Q/G_Q capture SUM/CYO/P/G on every CLK rise
//           0: registered outputs are tied to 0 and CLK/RST_N are unused
//
// Ports
//   CLK     in   rising-edge clock (registered outputs only)
//   RST_N   in   asynchronous active-low reset (registered outputs only)
//   A, B    in   operand bits
//   CYI     in   carry in
//   SUM     out  A ^ B ^ CYI                      (combinational)
//   CYO     out  (A & B) | (CYI & (A ^ B))        (combinational)
//   P       out  propagate, A ^ B                 (combinational)
//   G       out  generate,  A & B                 (combinational)
//   SUM_Q   out  SUM registered on CLK
//   CYO_Q   out  CYO registered on CLK
//   P_Q     out  P registered on CLK
//   G_Q     out  G registered on CLK
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int unsigned REG_EN = 32'd1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic A,
    input  logic B,
    input  logic CYI,
    output logic SUM,
    output logic CYO,
    output logic P,
    output logic G,
    output logic SUM_Q,
    output logic CYO_Q,
    output logic P_Q,
    output logic G_Q
);

    // Packs the four slice terms as {g, p, cyo, sum}. The carry is formed from
    // the propagate/generate terms so CYI reaches CYO through only an AND and
    // an OR, keeping the per-slice ripple delay at two gate levels.
    function automatic logic [3:0] fa_terms(input logic a, input logic b, input logic ci);
        logic p_l;
        logic g_l;
        p_l = a ^ b;
        g_l = a & b;
        return {g_l, p_l, g_l | (p_l & ci), p_l ^ ci};
    endfunction

    logic sum_d;
    logic cyo_d;
    logic p_d;
    logic g_d;

    logic sum_q;
    logic cyo_q;
    logic p_q;
    logic g_q;

    // Combinational slice terms; plain gates so X/Z on an input is not masked.
    always_comb begin
        sum_d = 1'b0;
        cyo_d = 1'b0;
        p_d   = 1'b0;
        g_d   = 1'b0;
        {g_d, p_d, cyo_d, sum_d} = fa_terms(A, B, CYI);
    end

    assign SUM = sum_d;
    assign CYO = cyo_d;
    assign P   = p_d;
    assign G   = g_d;

    generate
        if (REG_EN != 32'd0) begin : g_reg
            // Registered copy of the slice terms, cleared at once by RST_N.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    sum_q <= 1'b0;
                    cyo_q <= 1'b0;
                    p_q   <= 1'b0;
                    g_q   <= 1'b0;
                end else begin
                    sum_q <= sum_d;
                    cyo_q <= cyo_d;
                    p_q   <= p_d;
                    g_q   <= g_d;
                end
            end
        end else begin : g_noreg
            assign sum_q = 1'b0;
            assign cyo_q = 1'b0;
            assign p_q   = 1'b0;
            assign g_q   = 1'b0;
        end
    endgenerate

    assign SUM_Q = sum_q;
    assign CYO_Q = cyo_q;
    assign P_Q   = p_q;
    assign G_Q   = g_q;

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Directed testbench for full_adder: exhaustive truth table on the
// combinational outputs, reset/latency/async-reset behaviour of the
// registered outputs, and a 16-slice ripple chain with CLK/RST_N tied off.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic cyi;
    logic sum;
    logic cyo;
    logic p;
    logic g;
    logic sum_q;
    logic cyo_q;
    logic p_q;
    logic g_q;

    int checks_cnt;
    int errors_cnt;

    full_adder #(.REG_EN(32'd1)) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .A     (a),
        .B     (b),
        .CYI   (cyi),
        .SUM   (sum),
        .CYO   (cyo),
        .P     (p),
        .G     (g),
        .SUM_Q (sum_q),
        .CYO_Q (cyo_q),
        .P_Q   (p_q),
        .G_Q   (g_q)
    );

    // 16-slice ripple chain, clock held low and reset held asserted.
    logic [15:0] ch_a;
    logic [15:0] ch_b;
    logic        ch_ci;
    logic [16:0] ch_carry;
    logic [15:0] ch_sum;
    logic [15:0] ch_p;
    logic [15:0] ch_g;
    logic [15:0] ch_sum_q;
    logic [15:0] ch_cyo_q;
    logic [15:0] ch_p_q;
    logic [15:0] ch_g_q;

    assign ch_carry[0] = ch_ci;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_chain
            full_adder #(.REG_EN(32'd1)) u_slice (
                .CLK   (1'b0),
                .RST_N (1'b0),
                .A     (ch_a[gi]),
                .B     (ch_b[gi]),
                .CYI   (ch_carry[gi]),
                .SUM   (ch_sum[gi]),
                .CYO   (ch_carry[gi+1]),
                .P     (ch_p[gi]),
                .G     (ch_g[gi]),
                .SUM_Q (ch_sum_q[gi]),
                .CYO_Q (ch_cyo_q[gi]),
                .P_Q   (ch_p_q[gi]),
                .G_Q   (ch_g_q[gi])
            );
        end
    endgenerate

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt = checks_cnt + 1;
        if (obs !== exp) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hand-computed truth table, row index = {a,b,cyi}.
    logic [1:0] exp_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic       exp_p  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_g  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Chain vectors: a, b, ci, expected sum, expected carry out.
    logic [15:0] vec_a   [3] = '{16'h1111, 16'h1111, 16'hFFFF};
    logic [15:0] vec_b   [3] = '{16'h1111, 16'h1234, 16'h0000};
    logic        vec_ci  [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] vec_sum [3] = '{16'h2222, 16'h2346, 16'h0000};
    logic        vec_co  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] vec_p   [3] = '{16'h0000, 16'h0325, 16'hFFFF};
    logic [15:0] vec_g   [3] = '{16'h1111, 16'h1010, 16'h0000};

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n = 1'b0;
        a     = 1'b1;
        b     = 1'b1;
        cyi   = 1'b1;
        ch_a  = 16'h0000;
        ch_b  = 16'h0000;
        ch_ci = 1'b0;

        // Reset held with all-ones inputs across several edges.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sum_q", {63'd0, sum_q}, 64'd0);
        check_eq("rst_cyo_q", {63'd0, cyo_q}, 64'd0);
        check_eq("rst_p_q",   {63'd0, p_q},   64'd0);
        check_eq("rst_g_q",   {63'd0, g_q},   64'd0);
        check_eq("rst_sum",   {63'd0, sum},   64'd1);
        check_eq("rst_cyo",   {63'd0, cyo},   64'd1);

        // Exhaustive truth table (still in reset: combinational path only).
        for (int i = 0; i < 8; i++) begin
            logic [2:0] row;
            row = 3'(i);
            {a, b, cyi} = row;
            #2;
            check_eq($sformatf("tt_cs_%0d", i), {62'd0, cyo, sum}, {62'd0, exp_cs[i]});
            check_eq($sformatf("tt_p_%0d", i),  {63'd0, p},        {63'd0, exp_p[i]});
            check_eq($sformatf("tt_g_%0d", i),  {63'd0, g},        {63'd0, exp_g[i]});
            check_eq($sformatf("tt_id_%0d", i), {63'd0, cyo},      {63'd0, g | (p & cyi)});
        end
        check_eq("tt_rst_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'd0);

        // Release reset away from the edge, then check one-cycle latency.
        @(negedge clk);
        rst_n = 1'b1;
        a = 1'b1; b = 1'b0; cyi = 1'b0;
        #1;
        check_eq("pre_edge_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'd0);
        @(posedge clk);
        #1;
        check_eq("lat1_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'b1010);
        a = 1'b1; b = 1'b1; cyi = 1'b0;
        #2;
        check_eq("lat2_hold_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'b1010);
        @(posedge clk);
        #1;
        check_eq("lat2_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'b0101);

        // All-ones inputs captured, then async reset between edges.
        a = 1'b1; b = 1'b1; cyi = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ones_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'b1101);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'd0);
        check_eq("async_rst_comb", {62'd0, cyo, sum}, 64'b11);
        @(posedge clk);
        #1;
        check_eq("rst_hold_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rerelease_q", {60'd0, sum_q, cyo_q, p_q, g_q}, 64'b1101);

        // Ripple chain vectors.
        for (int k = 0; k < 3; k++) begin
            ch_a  = vec_a[k];
            ch_b  = vec_b[k];
            ch_ci = vec_ci[k];
            #2;
            check_eq($sformatf("chain_sum_%0d", k), {48'd0, ch_sum}, {48'd0, vec_sum[k]});
            check_eq($sformatf("chain_co_%0d", k),  {63'd0, ch_carry[16]}, {63'd0, vec_co[k]});
            check_eq($sformatf("chain_pg_%0d", k),  {32'd0, ch_p, ch_g}, {32'd0, vec_p[k], vec_g[k]});
            check_eq($sformatf("chain_q_%0d", k),   {ch_sum_q, ch_cyo_q, ch_p_q, ch_g_q}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
